// File: rtl/writeback_arbiter.sv
// Register-file write port arbiter: ALU results go straight through, long-latency results are buffered.
// The ALU has priority, a starve counter forces the FIFO head through, and hazards flag pending rd.
module writeback_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   alu_valid,
    input  logic [4:0]             alu_rd,
    input  logic [31:0]            alu_data,
    output logic                   alu_hold,
    input  logic                   ls_valid,
    output logic                   ls_ready,
    input  logic [4:0]             ls_rd,
    input  logic [31:0]            ls_data,
    output logic                   write,
    output logic [4:0]             writeaddr,
    output logic [31:0]            writedata,
    input  logic [4:0]             qaddr1,
    input  logic [4:0]             qaddr2,
    input  logic [4:0]             qaddr3,
    output logic                   hazard1,
    output logic                   hazard2,
    output logic                   hazard3,
    output logic [$clog2(DEPTH):0] pending
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]  r_rd   [DEPTH];
    logic [31:0] r_data [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;

    logic w_nonempty;
    logic w_full;
    logic w_force;
    logic w_sel_alu;
    logic w_sel_fifo;
    logic w_push;
    logic w_pop;
    logic [AW-1:0] w_off;
    logic [2:0] w_haz;

    assign w_nonempty = (r_count != '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_force    = w_nonempty && (r_starve == SW'(STARVE_LIMIT));
    assign w_sel_alu  = alu_valid && !w_force;
    assign w_sel_fifo = !w_sel_alu && w_nonempty;

    assign ls_ready = ~reset & ~w_full;
    // Zero-destination results are acknowledged but never stored.
    assign w_push   = ls_valid & ls_ready & (ls_rd != 5'd0);
    assign w_pop    = ~reset & w_sel_fifo & ~stall;

    assign write     = ~reset & (w_sel_alu | w_sel_fifo);
    assign alu_hold  = ~reset & w_sel_fifo & alu_valid;
    assign writeaddr = reset ? 5'd0 :
                       w_sel_alu ? alu_rd :
                       w_sel_fifo ? r_rd[r_head] : 5'd0;
    assign writedata = reset ? 32'd0 :
                       w_sel_alu ? alu_data :
                       w_sel_fifo ? r_data[r_head] : 32'd0;
    assign pending   = reset ? '0 : r_count;

    always_comb begin
        w_haz = 3'b000;
        w_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = AW'(i) - r_head;
            if ({1'b0, w_off} < r_count) begin
                if (r_rd[i] == qaddr1) w_haz[0] = 1'b1;
                if (r_rd[i] == qaddr2) w_haz[1] = 1'b1;
                if (r_rd[i] == qaddr3) w_haz[2] = 1'b1;
            end
        end
    end

    assign hazard1 = ~reset & w_haz[0] & (qaddr1 != 5'd0);
    assign hazard2 = ~reset & w_haz[1] & (qaddr2 != 5'd0);
    assign hazard3 = ~reset & w_haz[2] & (qaddr3 != 5'd0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_tail]   <= ls_rd;
            r_data[r_tail] <= ls_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_starve <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + AW'(1);
            if (w_pop)  r_head <= r_head + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (!w_nonempty || w_pop)
                r_starve <= '0;
            else if (!stall && w_sel_alu && r_starve != SW'(STARVE_LIMIT))
                r_starve <= r_starve + SW'(1);
        end
    end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Merges results from the single-cycle ALU pipe and the multi-cycle load/muldiv unit onto the register file's single write port (`write`/`writeaddr`/`writedata`). Buffers long-latency results in a small FIFO, gives the ALU priority with a starvation guard, and reports pending-destination hazards back to decode. It sits between execute/memory and the register file and obeys the register file's rule that writes are ignored while `stall` is high.

## Interface
- `DEPTH`, 2: long-latency result FIFO entries (power of two, ≥2).
- `STARVE_LIMIT`, 4: consecutive cycles a non-empty FIFO may lose to the ALU before it is forced through.
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: pipeline stall; same signal the register file sees.
- `alu_valid` in 1: ALU result present this cycle.
- `alu_rd` in 5 / `alu_data` in 32: ALU destination and value.
- `alu_hold` out 1: ALU result not taken this cycle; upstream must hold it.
- `ls_valid` in 1 / `ls_ready` out 1: long-latency result handshake; transfer when both high at a rising edge.
- `ls_rd` in 5 / `ls_data` in 32: long-latency destination and value.
- `write` out 1 / `writeaddr` out 5 / `writedata` out 32: register file write port.
- `qaddr1`, `qaddr2`, `qaddr3` in 5 each: decode's rs1, rs2, rd.
- `hazard1`, `hazard2`, `hazard3` out 1 each: matching query address has a buffered pending write.
- `pending` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- FIFO: circular, head/tail pointers plus count; FIFO order preserved for long-latency results.
- Accept: `ls_ready = ~reset & (count != DEPTH)`; no pass-through when full. Accept is independent of `stall`. Accepted entries with `ls_rd == 0` are discarded (not pushed, count unchanged).
- Selection each cycle (combinational):
  - force = FIFO non-empty and starve counter == STARVE_LIMIT.
  - If `alu_valid` and not force: drive ALU result; `alu_hold = 0`.
  - Else if FIFO non-empty: drive head entry; `alu_hold = alu_valid`.
  - Else: `write = 0`, `alu_hold = 0`.
- `write` is driven even while `stall` is high; pop happens only when the head entry is selected and `stall` is low.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Starve counter: reset to 0 when FIFO empty or when a pop occurs; increments (saturating at STARVE_LIMIT) when FIFO non-empty, ALU wins, and `stall` is low; holds while `stall` is high.
- Hazards: `hazardN = (qaddrN != 0)` and any occupied FIFO entry has rd == qaddrN. The entry popped this cycle still counts; entries being accepted this cycle do not.
- `alu_rd == 0` is passed through unchanged (the register file drops it).

## Timing
- Reset values, registered and visible the cycle after reset: count 0, pointers 0, starve counter 0. While `reset` is high, all outputs are forced to 0: `write`, `ls_ready`, `alu_hold`, hazards, `pending`.
- ALU path latency is 0 cycles: the write lands on the same edge as the ALU result.
- Long-latency path: a result accepted at edge N is written at edge N+1 at the earliest.
- `pending` and hazards reflect registered state only.
- Reset asserted mid-operation flushes all buffered entries; they are never written.
- Worst-case wait for a FIFO head under continuous ALU traffic is STARVE_LIMIT+1 unstalled cycles.

## Test plan
- Reset then idle: `write=0`, `ls_ready=1`, `pending=0`, hazards 0.
- Long-latency only: accept rd=5, data 0xDEADBEEF at edge N → `write=1`, `writeaddr=5`, `writedata=0xDEADBEEF` during cycle N+1; `pending` returns to 0 after edge N+1.
- Fill: with `alu_valid` held high, push rd=1 and rd=2 (DEPTH=2) → `ls_ready=0`, `pending=2`, `hazard1=1` for qaddr1=2. Starvation: after 4 unstalled cycles the head (rd=1) is written, `alu_hold=1` that cycle, and the ALU result is written the following cycle.
- Stall: buffer rd=7 with `stall=1` for 3 cycles → `write=1` stays asserted, entry is not popped, `pending=1`; it pops on the first cycle with `stall=0`.
- Simultaneous push/pop on a 1-entry FIFO with ALU idle → `pending` stays 1 and entries are written in acceptance order. `ls_rd=0` accepted → no push, `pending` unchanged.
- Reset mid-operation with 2 entries buffered → after reset `pending=0` and no write of the flushed entries ever appears.
